// File: rtl/fpu_fetch_sequencer.sv
// rtl/fpu_fetch_sequencer.sv - UART program loader and in-order instruction fetch sequencer
module fpu_fetch_sequencer #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 8,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  input  logic              done_i,
  input  logic              stall_i,
  output logic              load_done_o,
  output logic              halt_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);
  localparam int                NB       = DATA_W / 8;
  localparam int                IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);
  localparam logic [1:0]        LAT_LAST = 2'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [DATA_W-1:0] END_W    = DATA_W'(END_WORD);

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_EXEC, S_HALT
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] asm_word, word_nx;
  logic [ADDR_W-1:0] waddr, pc;
  logic [ADDR_W:0]   word_count;
  logic [1:0]        lat_cnt;
  logic              done_pend, we_q, load_done_q, overflow_q;
  logic [DATA_W-1:0] wdata_q, instr_q;
  logic              last_byte, is_end, full_now, advance, last_instr;

  // Word as it would look with the incoming byte merged in (little-endian)
  always_comb begin
    word_nx = asm_word;
    word_nx[{byte_idx, 3'b000} +: 8] = rx_byte_i;
  end

  assign last_byte  = rx_dv_i && (byte_idx == LAST_IDX);
  assign is_end     = (word_nx == END_W);
  assign full_now   = we_q && ((word_count + (ADDR_W+1)'(1)) == DEPTH);
  assign advance    = done_pend && !stall_i;
  assign last_instr = (instr_q == END_W) ||
                      (({1'b0, pc} + (ADDR_W+1)'(1)) == word_count);

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: begin
        if (full_now)
          state_nx = S_FETCH;
        else if (last_byte && is_end)
          state_nx = (word_count == '0) ? S_HALT : S_FETCH;
      end
      S_FETCH:     state_nx = S_WAIT_MEM;
      S_WAIT_MEM:  if (lat_cnt == LAT_LAST) state_nx = S_ISSUE;
      S_ISSUE:     state_nx = S_WAIT_EXEC;
      S_WAIT_EXEC: if (advance) state_nx = last_instr ? S_HALT : S_FETCH;
      S_HALT:      if (rx_dv_i) state_nx = S_LOAD;
      default:     state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= S_LOAD;
      byte_idx    <= '0;
      asm_word    <= '0;
      waddr       <= '0;
      pc          <= '0;
      word_count  <= '0;
      lat_cnt     <= '0;
      done_pend   <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      instr_q     <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state <= state_nx;
      we_q  <= 1'b0;
      case (state)
        S_LOAD: begin
          if (rx_dv_i) begin
            asm_word <= word_nx;
            byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
            if (last_byte && !is_end && !full_now) begin
              we_q    <= 1'b1;
              wdata_q <= word_nx;
            end
          end
          if (we_q) begin
            waddr      <= waddr + ADDR_W'(1);
            word_count <= word_count + (ADDR_W+1)'(1);
          end
          if (full_now) overflow_q <= 1'b1;
          if (state_nx != S_LOAD) begin
            load_done_q <= 1'b1;
            pc          <= '0;
          end
        end
        S_WAIT_MEM: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            instr_q <= mem_rdata_i;
          end
        end
        S_ISSUE: if (done_i) done_pend <= 1'b1;
        S_WAIT_EXEC: begin
          if (advance) begin
            done_pend <= 1'b0;
            pc        <= pc + ADDR_W'(1);
          end else if (done_i) begin
            done_pend <= 1'b1;
          end
        end
        S_HALT: begin
          // Reload: the waking byte is the first byte of the new program
          if (rx_dv_i) begin
            asm_word[7:0] <= rx_byte_i;
            byte_idx      <= IDX_W'(1);
            waddr         <= '0;
            word_count    <= '0;
            load_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o      = we_q;
  assign mem_waddr_o   = waddr;
  assign mem_wdata_o   = wdata_q;
  assign mem_re_o      = (state == S_FETCH);
  assign mem_raddr_o   = pc;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state == S_ISSUE);
  assign load_done_o   = load_done_q;
  assign halt_o        = (state == S_HALT);
  assign overflow_o    = overflow_q;
  assign word_count_o  = word_count;

endmodule

// File: tb/tb_fpu_fetch_sequencer.sv
// tb/tb_fpu_fetch_sequencer.sv - scoreboard bench for a default and a small/slow-memory sequencer
module tb_fpu_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rx_dv, done, stall;
  logic [1:0][7:0]  rx_byte;
  logic [1:0]       we, re, iv, ld, hl, ov;
  logic [1:0][7:0]  wa, ra;
  logic [1:0][31:0] wd, ins, rd;
  logic [1:0][8:0]  wc;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [4];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid [2];
  int re_cyc [2];
  logic [7:0] re_addr [2];

  logic [40:0] q_wr [$];
  logic [39:0] q_in0 [$];
  logic [39:0] q_in1 [$];
  logic [40:0] ew;
  logic [39:0] ei;

  typedef struct {
    int          d;
    logic [31:0] word;
    logic        wr;
    logic [7:0]  addr;
    logic [8:0]  cnt;
  } ld_vec_t;
  ld_vec_t vt [8];

  fpu_fetch_sequencer u_dut0 (
    .clk(clk), .rst_l(rst_l), .rx_dv_i(rx_dv[0]), .rx_byte_i(rx_byte[0]),
    .mem_we_o(we[0]), .mem_waddr_o(wa[0]), .mem_wdata_o(wd[0]),
    .mem_re_o(re[0]), .mem_raddr_o(ra[0]), .mem_rdata_i(rd[0]),
    .instr_o(ins[0]), .instr_valid_o(iv[0]), .done_i(done[0]), .stall_i(stall[0]),
    .load_done_o(ld[0]), .halt_o(hl[0]), .overflow_o(ov[0]), .word_count_o(wc[0])
  );

  fpu_fetch_sequencer #(.ADDR_W(2), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .rst_l(rst_l), .rx_dv_i(rx_dv[1]), .rx_byte_i(rx_byte[1]),
    .mem_we_o(we[1]), .mem_waddr_o(wa[1][1:0]), .mem_wdata_o(wd[1]),
    .mem_re_o(re[1]), .mem_raddr_o(ra[1][1:0]), .mem_rdata_i(rd[1]),
    .instr_o(ins[1]), .instr_valid_o(iv[1]), .done_i(done[1]), .stall_i(stall[1]),
    .load_done_o(ld[1]), .halt_o(hl[1]), .overflow_o(ov[1]), .word_count_o(wc[1][2:0])
  );
  assign wa[1][7:2] = '0;
  assign ra[1][7:2] = '0;
  assign wc[1][8:3] = '0;

  // SRAM models; non-read cycles return garbage so a mistimed capture shows up
  always @(posedge clk) begin
    pipe0    <= re[0] ? mem0[ra[0]] : 32'hDEAD_BEEF;
    pipe1[0] <= re[1] ? mem1[ra[1][1:0]] : 32'hDEAD_BEEF;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rd[0] = pipe0;
  assign rd[1] = pipe1[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (we[d]) begin
        if (d == 0) mem0[wa[0]] = wd[0];
        else        mem1[wa[1][1:0]] = wd[1];
        if (q_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write%0d: got addr %0h data %0h expected none", d, wa[d], wd[d]);
        end else begin
          ew = q_wr.pop_front();
          check($sformatf("wr_dut%0d", d), 64'(d), 64'(ew[40]));
          check($sformatf("wr_addr%0d", d), 64'(wa[d]), 64'(ew[39:32]));
          check($sformatf("wr_data%0d", d), 64'(wd[d]), 64'(ew[31:0]));
        end
      end
      if (re[d]) begin
        re_cyc[d]  = cyc;
        re_addr[d] = ra[d];
      end
      if (iv[d]) begin
        nvalid[d]++;
        check($sformatf("latency%0d", d), 64'(cyc - re_cyc[d]), (d == 0) ? 64'd2 : 64'd4);
        if ((d == 0 && q_in0.size() == 0) || (d == 1 && q_in1.size() == 0)) begin
          tests++; fails++;
          $display("FAIL unexpected_issue%0d: got instr %0h expected none", d, ins[d]);
        end else begin
          ei = (d == 0) ? q_in0.pop_front() : q_in1.pop_front();
          check($sformatf("fetch_pc%0d", d), 64'(re_addr[d]), 64'(ei[39:32]));
          check($sformatf("instr%0d", d), 64'(ins[d]), 64'(ei[31:0]));
        end
      end
    end
  end

  task automatic send_byte(input int d, input logic [7:0] b);
    rx_byte[d] = b;
    rx_dv[d]   = 1'b1;
    @(negedge clk);
    rx_dv[d]   = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input int d, input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(d, w[8*b +: 8]);
  endtask

  task automatic wait_valid(input int d, input int n);
    int t = 0;
    while (nvalid[d] < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (nvalid[d] < n) begin
      tests++; fails++;
      $display("FAIL wait_valid%0d: got %0d issues expected %0d", d, nvalid[d], n);
    end
  endtask

  task automatic pulse_done(input int d);
    done[d] = 1'b1;
    @(negedge clk);
    done[d] = 1'b0;
  endtask

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s_we%0d", tag, d), 64'(we[d]), 64'd0);
    check($sformatf("%s_re%0d", tag, d), 64'(re[d]), 64'd0);
    check($sformatf("%s_valid%0d", tag, d), 64'(iv[d]), 64'd0);
    check($sformatf("%s_load_done%0d", tag, d), 64'(ld[d]), 64'd0);
    check($sformatf("%s_halt%0d", tag, d), 64'(hl[d]), 64'd0);
    check($sformatf("%s_overflow%0d", tag, d), 64'(ov[d]), 64'd0);
    check($sformatf("%s_count%0d", tag, d), 64'(wc[d]), 64'd0);
    check($sformatf("%s_instr%0d", tag, d), 64'(ins[d]), 64'd0);
    check($sformatf("%s_waddr%0d", tag, d), 64'(wa[d]), 64'd0);
    check($sformatf("%s_wdata%0d", tag, d), 64'(wd[d]), 64'd0);
    check($sformatf("%s_raddr%0d", tag, d), 64'(ra[d]), 64'd0);
  endtask

  initial begin
    rx_dv = '0; rx_byte = '0; done = '0; stall = '0;
    nvalid[0] = 0; nvalid[1] = 0; re_cyc[0] = 0; re_cyc[1] = 0;
    vt[0] = '{1, 32'h1111_0001, 1'b1, 8'd0, 9'd1};
    vt[1] = '{1, 32'h2222_0002, 1'b1, 8'd1, 9'd2};
    vt[2] = '{1, 32'h3333_0003, 1'b1, 8'd2, 9'd3};
    vt[3] = '{1, 32'h4444_0004, 1'b1, 8'd3, 9'd4};
    vt[4] = '{1, 32'h5555_0005, 1'b0, 8'd0, 9'd4};
    vt[5] = '{0, 32'h0010_0513, 1'b1, 8'd0, 9'd1};
    vt[6] = '{0, 32'h0020_0593, 1'b1, 8'd1, 9'd2};
    vt[7] = '{0, 32'h0000_0FFF, 1'b0, 8'd0, 9'd2};

    repeat (3) @(negedge clk);
    check_idle(0, "reset");
    check_idle(1, "reset");
    rst_l = 1'b1;
    @(negedge clk);

    // Loads: dut1 overflows its 4-word memory, dut0 gets a 2-word program
    for (int i = 0; i < 8; i++) begin
      if (vt[i].wr) begin
        q_wr.push_back({vt[i].d[0], vt[i].addr, vt[i].word});
        if (vt[i].d == 0) q_in0.push_back({vt[i].addr, vt[i].word});
        else              q_in1.push_back({vt[i].addr, vt[i].word});
      end
      send_word(vt[i].d, vt[i].word);
      repeat (2) @(negedge clk);
      check($sformatf("word_count_vec%0d", i), 64'(wc[vt[i].d]), 64'(vt[i].cnt));
    end
    check("load_done0", 64'(ld[0]), 64'd1);
    check("overflow0", 64'(ov[0]), 64'd0);
    check("load_done1", 64'(ld[1]), 64'd1);
    check("overflow1", 64'(ov[1]), 64'd1);

    for (int i = 0; i < 2; i++) begin
      wait_valid(0, i + 1);
      repeat (3) @(negedge clk);
      pulse_done(0);
    end
    repeat (2) @(negedge clk);
    check("halt0_a", 64'(hl[0]), 64'd1);
    check("halt0_pc", 64'(ra[0]), 64'd2);
    check("halt0_instr_held", 64'(ins[0]), 64'h0020_0593);

    for (int i = 0; i < 4; i++) begin
      wait_valid(1, i + 1);
      repeat (3) @(negedge clk);
      pulse_done(1);
    end
    repeat (2) @(negedge clk);
    check("halt1", 64'(hl[1]), 64'd1);
    check("halt1_count", 64'(wc[1]), 64'd4);

    // Reload from HALT: first byte wakes the loader and is kept
    q_wr.push_back({1'b0, 8'd0, 32'hCAFE_0001});
    q_wr.push_back({1'b0, 8'd1, 32'hBEEF_0002});
    q_in0.push_back({8'd0, 32'hCAFE_0001});
    q_in0.push_back({8'd1, 32'hBEEF_0002});
    send_byte(0, 8'h01);
    check("reload_load_done", 64'(ld[0]), 64'd0);
    check("reload_halt", 64'(hl[0]), 64'd0);
    check("reload_count", 64'(wc[0]), 64'd0);
    send_byte(0, 8'h00);
    send_byte(0, 8'hFE);
    send_byte(0, 8'hCA);
    send_word(0, 32'hBEEF_0002);
    send_word(0, 32'h0000_0FFF);

    wait_valid(0, 3);
    stall[0] = 1'b1;
    @(negedge clk);
    pulse_done(0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_re%0d", k), 64'(re[0]), 64'd0);
    end
    stall[0] = 1'b0;
    @(negedge clk);
    check("stall_release_re", 64'(re[0]), 64'd1);
    check("stall_release_pc", 64'(ra[0]), 64'd1);
    wait_valid(0, 4);
    repeat (3) @(negedge clk);
    pulse_done(0);
    repeat (2) @(negedge clk);
    check("halt0_b", 64'(hl[0]), 64'd1);

    // Reset in the middle of a word discards the partial bytes
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    rst_l = 1'b0;
    @(negedge clk);
    check_idle(0, "midreset");
    check_idle(1, "midreset");
    rst_l = 1'b1;
    @(negedge clk);
    q_wr.push_back({1'b0, 8'd0, 32'h1234_5678});
    send_word(0, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check("post_reset_count", 64'(wc[0]), 64'd1);

    repeat (4) @(negedge clk);
    check("writes_left", 64'(q_wr.size()), 64'd0);
    check("issues_left0", 64'(q_in0.size()), 64'd0);
    check("issues_left1", 64'(q_in1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
